dsm_cic_decimator: RTL and testbench

- Receive-side counterpart of the DSM transmit path. Accepts the modulator output sample stream: either the signed MASH word or the 1-bit DSM bitstream.
- Reconstructs OUT_WIDTH-bit PCM samples with a Hogenauer CIC decimator: ORDER integrators, a decimate-by-DEC_RATE stage, then ORDER combs (M=1).
- Used in loopback benches and on-chip self-test to recover the NCO tone from tx_i/q modulator outputs.

---
 rtl/dsm_rx_pkg.sv | 34 +++
 rtl/cic_comb_stage.sv | 42 ++++
 rtl/dsm_cic_decimator.sv | 136 +++++++++++++
 tb/tb_dsm_cic_decimator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dsm_rx_pkg.sv
// -----------------------------------------------------------------------------
// dsm_rx_pkg : shared helpers for the DSM receive-side CIC decimator (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

package dsm_rx_pkg;

  function automatic int acc_width(input int in_w, input int order, input int rate);
    return in_w + order * $clog2(rate);
  endfunction

  // A +/-1 value needs a sign bit plus one magnitude bit; narrower targets get 0.
  function automatic logic signed [63:0] bit_to_pm1(input logic b, input int width);
    logic signed [63:0] v;
    v = b ? 64'sd1 : -64'sd1;
    if (width < 2) v = '0;
    return v;
  endfunction

  function automatic bit order_legal(input int order);
    return (order >= 1) && (order <= 5);
  endfunction

  function automatic bit rate_legal(input int rate, input int order);
    return (rate > order + 1) && ((rate & (rate - 1)) == 0);
  endfunction

  function automatic bit width_legal(input int out_w, input int acc_w);
    return (out_w >= 1) && (out_w <= acc_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic_comb_stage.sv
// -----------------------------------------------------------------------------
// cic_comb_stage : one M=1 comb section, c <= y - y(prev token) (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module cic_comb_stage #(
  parameter int WIDTH = 18
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] c_out
);

  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] dly_q, dly_d;

  always_comb begin
    c_d   = c_q;
    dly_d = dly_q;
    if (en) begin
      c_d   = y_in - dly_q;
      dly_d = y_in;
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      c_q   <= '0;
      dly_q <= '0;
    end else begin
      c_q   <= c_d;
      dly_q <= dly_d;
    end
  end

  assign c_out = c_q;

endmodule

`default_nettype wire

// File: rtl/dsm_cic_decimator.sv
// -----------------------------------------------------------------------------
// dsm_cic_decimator : Hogenauer CIC decimator recovering PCM from DSM output (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module dsm_cic_decimator
  import dsm_rx_pkg::*;
#(
  parameter int IN_WIDTH  = 3,
  parameter int BITSTREAM = 0,
  parameter int ORDER     = 3,
  parameter int DEC_RATE  = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [IN_WIDTH-1:0]         in_data,
  output logic                        out_valid,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic [$clog2(DEC_RATE)-1:0] dec_phase
);

  localparam int ACC_WIDTH = acc_width(IN_WIDTH, ORDER, DEC_RATE);
  localparam int PH_W      = $clog2(DEC_RATE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DEC_RATE - 1);

  if (!order_legal(ORDER)) begin : g_bad_order
    $error("dsm_cic_decimator: ORDER must be in 1..5");
  end
  if (!rate_legal(DEC_RATE, ORDER)) begin : g_bad_rate
    $error("dsm_cic_decimator: DEC_RATE must be a power of two above ORDER+1");
  end
  if (!width_legal(OUT_WIDTH, ACC_WIDTH)) begin : g_bad_width
    $error("dsm_cic_decimator: OUT_WIDTH must not exceed ACC_WIDTH");
  end

  logic [ACC_WIDTH-1:0] x;
  logic signed [63:0]   pm1_full;
  logic                 unused_bits;

  assign pm1_full    = bit_to_pm1(in_data[0], ACC_WIDTH);
  assign unused_bits = ^{in_data, pm1_full};

  if (BITSTREAM != 0) begin : g_bitstream
    assign x = pm1_full[ACC_WIDTH-1:0];
  end else begin : g_pcm
    assign x = ACC_WIDTH'($signed(in_data));
  end

  // Integrators wrap freely; the matching combs cancel the modulo error.
  logic [ACC_WIDTH-1:0] integ_in  [ORDER];
  logic [ACC_WIDTH-1:0] integ_out [ORDER];

  for (genvar k = 0; k < ORDER; k++) begin : g_integ
    logic [ACC_WIDTH-1:0] acc_q, acc_d;

    if (k == 0) begin : g_first
      assign integ_in[k] = x;
    end else begin : g_chain
      assign integ_in[k] = integ_out[k-1];
    end

    always_comb begin
      acc_d = acc_q;
      if (in_valid) acc_d = acc_q + integ_in[k];
    end

    always_ff @(posedge aclk or posedge rst) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
    end

    assign integ_out[k] = acc_q;
  end

  logic [PH_W-1:0]      phase_q, phase_d;
  logic [ACC_WIDTH-1:0] dec_q, dec_d;
  logic [ORDER-1:0]     tok_q, tok_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_end;

  // tok_q[k] enables comb stage k+1, giving a fixed ORDER-cycle latency.
  always_comb begin
    frame_end   = in_valid && (phase_q == PH_LAST);
    phase_d     = phase_q;
    dec_d       = dec_q;
    tok_d       = '0;
    if (in_valid)  phase_d = phase_q + PH_W'(1);
    if (frame_end) dec_d = integ_out[ORDER-1];
    tok_d[0] = frame_end;
    for (int k = 1; k < ORDER; k++) tok_d[k] = tok_q[k-1];
    out_valid_d = tok_q[ORDER-1];
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      phase_q     <= '0;
      dec_q       <= '0;
      tok_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      dec_q       <= dec_d;
      tok_q       <= tok_d;
      out_valid_q <= out_valid_d;
    end
  end

  logic [ACC_WIDTH-1:0] comb_y [ORDER+1];
  assign comb_y[0] = dec_q;

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    cic_comb_stage #(
      .WIDTH (ACC_WIDTH)
    ) u_comb (
      .aclk  (aclk),
      .rst   (rst),
      .en    (tok_q[k]),
      .y_in  (comb_y[k]),
      .c_out (comb_y[k+1])
    );
  end

  if (ACC_WIDTH > OUT_WIDTH) begin : g_drop_lsbs
    logic unused_lsbs;
    assign unused_lsbs = ^comb_y[ORDER][ACC_WIDTH-OUT_WIDTH-1:0];
  end

  assign out_data  = comb_y[ORDER][ACC_WIDTH-1 -: OUT_WIDTH];
  assign out_valid = out_valid_q;
  assign dec_phase = phase_q;

endmodule

`default_nettype wire

// File: tb/tb_dsm_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_dsm_cic_decimator : scoreboard bench for PCM and bitstream decimators (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module tb_dsm_cic_decimator;

  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_data = 3'd0;
  logic        ov0, ov1;
  logic [15:0] od0, od1;
  logic [4:0]  ph0, ph1;

  always #5 aclk = ~aclk;

  dsm_cic_decimator #(
    .IN_WIDTH(3), .BITSTREAM(0), .ORDER(3), .DEC_RATE(32), .OUT_WIDTH(16)
  ) dut (
    .aclk(aclk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov0), .out_data(od0), .dec_phase(ph0)
  );

  dsm_cic_decimator #(
    .IN_WIDTH(3), .BITSTREAM(1), .ORDER(3), .DEC_RATE(32), .OUT_WIDTH(16)
  ) dut_bs (
    .aclk(aclk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_data(od1), .dec_phase(ph1)
  );

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference CIC: ACC=18 bit wrapping integrators, decimate by 32, three combs.
  longint m_int [2][3];
  longint m_dly [2][3];
  int     m_phase;
  longint q_dat0[$], q_dat1[$];
  int     q_cyc0[$], q_cyc1[$];

  function automatic longint wrap18(input longint v);
    longint r;
    r = v & 64'h3FFFF;
    if (r[17]) r = r - 64'h40000;
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 3; s++) begin
        m_int[c][s] = 0;
        m_dly[c][s] = 0;
      end
    m_phase = 0;
    q_dat0.delete(); q_dat1.delete();
    q_cyc0.delete(); q_cyc1.delete();
  endtask

  task automatic model_step(input logic [2:0] d, input int acc_cyc);
    longint x [2];
    longint y, cv;
    x[0] = longint'($signed(d));
    x[1] = d[0] ? 64'sd1 : -64'sd1;
    for (int c = 0; c < 2; c++) begin
      if (m_phase == 31) begin
        y = m_int[c][2];
        for (int s = 0; s < 3; s++) begin
          cv = wrap18(y - m_dly[c][s]);
          m_dly[c][s] = y;
          y = cv;
        end
        if (c == 0) begin q_dat0.push_back(y >>> 2); q_cyc0.push_back(acc_cyc); end
        else        begin q_dat1.push_back(y >>> 2); q_cyc1.push_back(acc_cyc); end
      end
      m_int[c][2] = wrap18(m_int[c][2] + m_int[c][1]);
      m_int[c][1] = wrap18(m_int[c][1] + m_int[c][0]);
      m_int[c][0] = wrap18(m_int[c][0] + x[c]);
    end
    m_phase = (m_phase + 1) % 32;
  endtask

  task automatic drive(input bit v, input logic [2:0] d);
    @(negedge aclk);
    check("dec_phase", ph0, m_phase);
    check("dec_phase_bs", ph1, m_phase);
    in_valid = v;
    in_data  = d;
    if (v) model_step(d, cyc + 1);
  endtask

  bit     sine_on = 1'b0;
  longint pk_max = 0, pk_min = 0;
  longint e0, e1;
  int     c0, c1;

  always @(negedge aclk) begin
    if (!rst && ov0) begin
      if (q_dat0.size() == 0) check("strobe_unexpected", ov0, 0);
      else begin
        e0 = q_dat0.pop_front();
        c0 = q_cyc0.pop_front();
        check("out_data", $signed(od0), e0);
        check("latency", cyc - c0, 3);
        if (sine_on) begin
          if ($signed(od0) > pk_max) pk_max = $signed(od0);
          if ($signed(od0) < pk_min) pk_min = $signed(od0);
        end
      end
    end
    if (!rst && ov1) begin
      if (q_dat1.size() == 0) check("strobe_unexpected_bs", ov1, 0);
      else begin
        e1 = q_dat1.pop_front();
        c1 = q_cyc1.pop_front();
        check("out_data_bs", $signed(od1), e1);
        check("latency_bs", cyc - c1, 3);
      end
    end
  end

  task automatic run_const(input logic [2:0] d, input int frames, input bit sparse);
    for (int i = 0; i < frames * 32; i++) begin
      drive(1'b1, d);
      if (sparse) repeat (3) drive(1'b0, d);
    end
    repeat (6) drive(1'b0, d);
  endtask

  task automatic check_steady(input string tag, input longint exp0, input longint exp1);
    check({tag, "_pcm"}, $signed(od0), exp0);
    check({tag, "_bs"}, $signed(od1), exp1);
  endtask

  real    u, w, e_q;
  int     v_q;

  initial begin
    model_clear();
    rst = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_out_data", od0, 0);
    check("rst_out_valid", ov0, 0);
    check("rst_dec_phase", ph0, 0);
    check("rst_out_data_bs", od1, 0);
    rst = 1'b0;

    run_const(3'd1, 8, 1'b0);
    check_steady("steady_p1", 8192, 8192);
    run_const(3'b100, 8, 1'b0);
    check_steady("steady_m4", -32768, -8192);
    run_const(3'b011, 8, 1'b0);
    check_steady("steady_p3", 24576, 8192);

    for (int i = 0; i < 8 * 32; i++) drive(1'b1, (i % 2 == 0) ? 3'd1 : 3'd0);
    repeat (6) drive(1'b0, 3'd0);
    check_steady("steady_alt", 4096, 0);

    run_const(3'd1, 5, 1'b1);
    check_steady("steady_sparse", 8192, 8192);

    // Mid-frame asynchronous reset at dec_phase 17.
    for (int i = 0; i < 64 && m_phase != 17; i++) drive(1'b1, 3'd1);
    @(posedge aclk);
    #2;
    check("pre_rst_phase", ph0, 17);
    check("pre_rst_out_data", $signed(od0), 8192);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("async_rst_out_data", od0, 0);
    check("async_rst_out_valid", ov0, 0);
    check("async_rst_dec_phase", ph0, 0);
    check("async_rst_out_data_bs", od1, 0);
    @(negedge aclk);
    @(negedge aclk);
    rst = 1'b0;
    model_clear();
    run_const(3'd1, 1, 1'b0);
    check("post_rst_q_empty", q_dat0.size(), 0);

    // Low-frequency tone through a first-order 3-bit modulator.
    e_q = 0.0;
    for (int n = 0; n < 2304; n++) begin
      u = 2.0 * $sin(2.0 * 3.14159265358979 * n / 512.0);
      w = u + e_q;
      v_q = $rtoi($floor(w + 0.5));
      if (v_q > 3) v_q = 3;
      if (v_q < -4) v_q = -4;
      e_q = w - v_q;
      if (n == 256) sine_on = 1'b1;
      drive(1'b1, v_q[2:0]);
    end
    repeat (6) drive(1'b0, 3'd0);
    sine_on = 1'b0;
    check("sine_peak_hi", (pk_max > 14500 && pk_max < 17500) ? 1 : 0, 1);
    check("sine_peak_lo", (pk_min < -14500 && pk_min > -17500) ? 1 : 0, 1);

    repeat (8) drive(1'b0, 3'd0);
    check("drain", q_dat0.size() + q_dat1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
